mem_responder: RTL and testbench

- Memory-side responder for the CPU data/instruction memory port.
- Accepts one word-aligned read or write request per handshake and services it from an internal word-organised RAM after a programmable number of wait states.
- Returns read data or a write acknowledge on a separate response channel.
- Lets the multicycle core and its testbenches run against realistic, stallable memory instead of a zero-latency array.

---
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_responder.sv | 161 ++++++++++++++++
 tb/tb_mem_responder.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between a CPU memory port (master) and mem_responder (slave).
//   req_valid/req_ready : request handshake
//   req_we              : 1 = write, 0 = read
//   req_addr            : byte address (must be word aligned)
//   req_wdata/req_be    : write data and byte enables (bit i -> bits 8i+7:8i)
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : read data (0 for writes and errors)
//   rsp_err             : request was misaligned or out of range
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one word-aligned read/write request at a time,
// services it from an internal word RAM after WAIT_CYCLES wait states and
// returns data or a write acknowledge on the response channel.
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset (RAM contents are kept)
//   bus : mem_responder_if slave port (request + response channels)
module mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_rdata;
  logic               r_rsp_err;
  logic [31:0]        r_mem [DEPTH];

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_req_ready;
  logic               w_accept;
  logic               w_access;
  logic               w_rsp_done;
  logic               w_op_we;
  logic [31:0]        w_op_addr;
  logic [31:0]        w_op_wdata;
  logic [3:0]         w_op_be;
  logic               w_err;
  logic [ADDR_WIDTH-1:0] w_idx;

  // Ready depends on state only, never on req_valid.
  assign w_req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_rsp_done  = r_rsp_valid && bus.rsp_ready;

  // With zero wait states the access happens on the accept edge, so the
  // operands come straight from the bus; otherwise from the latched copy.
  always_comb begin
    w_op_we    = r_we;
    w_op_addr  = r_addr;
    w_op_wdata = r_wdata;
    w_op_be    = r_be;
    if (r_state == S_IDLE) begin
      w_op_we    = bus.req_we;
      w_op_addr  = bus.req_addr;
      w_op_wdata = bus.req_wdata;
      w_op_be    = bus.req_be;
    end
  end

  assign w_err = (w_op_addr[1:0] != 2'b00) ||
                 ((w_op_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign w_idx = w_op_addr[ADDR_WIDTH+1:2];

  // Next-state / wait counter / access strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            w_access    = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_access    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (w_rsp_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_access) begin
        r_rsp_valid <= 1'b1;
        if (w_err) begin
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b1;
        end else if (w_op_we) begin
          r_rsp_rdata <= '0;
          r_rsp_err   <= 1'b0;
        end else begin
          r_rsp_rdata <= r_mem[w_idx];
          r_rsp_err   <= 1'b0;
        end
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Request capture; inputs are ignored after the accept edge.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= bus.req_we;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_be    <= bus.req_be;
    end
  end

  // RAM write port; a write still pending when reset arrives is dropped.
  always_ff @(posedge clk) begin
    if (w_access && !rst && w_op_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_op_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_op_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_CYCLES = 1, 0, 3) share the
// stimulus, gated by sel so only one is exercised at a time.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          sel;
  logic        tb_req_valid, tb_we, tb_rsp_ready;
  logic [31:0] tb_addr, tb_wdata;
  logic [3:0]  tb_be;
  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;

  int checks   = 0;
  int failures = 0;

  mem_responder_if u_if0 ();
  mem_responder_if u_if1 ();
  mem_responder_if u_if2 ();

  assign u_if0.req_valid = tb_req_valid && (sel == 0);
  assign u_if0.rsp_ready = tb_rsp_ready && (sel == 0);
  assign u_if0.req_we    = tb_we;
  assign u_if0.req_addr  = tb_addr;
  assign u_if0.req_wdata = tb_wdata;
  assign u_if0.req_be    = tb_be;

  assign u_if1.req_valid = tb_req_valid && (sel == 1);
  assign u_if1.rsp_ready = tb_rsp_ready && (sel == 1);
  assign u_if1.req_we    = tb_we;
  assign u_if1.req_addr  = tb_addr;
  assign u_if1.req_wdata = tb_wdata;
  assign u_if1.req_be    = tb_be;

  assign u_if2.req_valid = tb_req_valid && (sel == 2);
  assign u_if2.rsp_ready = tb_rsp_ready && (sel == 2);
  assign u_if2.req_we    = tb_we;
  assign u_if2.req_addr  = tb_addr;
  assign u_if2.req_wdata = tb_wdata;
  assign u_if2.req_be    = tb_be;

  mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_dut0 (.clk(clk), .rst(rst), .bus(u_if0.slave));
  mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1.slave));
  mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_dut2 (.clk(clk), .rst(rst), .bus(u_if2.slave));

  always_comb begin
    case (sel)
      1: begin
        o_req_ready = u_if1.req_ready; o_rsp_valid = u_if1.rsp_valid;
        o_rsp_rdata = u_if1.rsp_rdata; o_rsp_err   = u_if1.rsp_err;
      end
      2: begin
        o_req_ready = u_if2.req_ready; o_rsp_valid = u_if2.rsp_valid;
        o_rsp_rdata = u_if2.rsp_rdata; o_rsp_err   = u_if2.rsp_err;
      end
      default: begin
        o_req_ready = u_if0.req_ready; o_rsp_valid = u_if0.rsp_valid;
        o_rsp_rdata = u_if0.rsp_rdata; o_rsp_err   = u_if0.rsp_err;
      end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting on DUT (t=%0t)", name, $time);
  endtask

  // One full transaction, entered and left at a negedge.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold, input int exp_lat,
                     output logic [31:0] rdata, output logic err);
    int n;
    int lat;
    n     = 0;
    rdata = 32'h0;
    err   = 1'b0;
    while (!o_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_req_ready) begin
      timeout_fail("req_ready_wait");
      return;
    end
    tb_req_valid = 1'b1;
    tb_we        = we;
    tb_addr      = addr;
    tb_wdata     = wdata;
    tb_be        = be;
    tb_rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    tb_req_valid = 1'b0;
    tb_we        = ~we;
    tb_addr      = ~addr;
    tb_wdata     = ~wdata;
    tb_be        = ~be;
    lat = 1;
    while (!o_rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!o_rsp_valid) begin
      timeout_fail("rsp_valid_wait");
      return;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    rdata = o_rsp_rdata;
    err   = o_rsp_err;
    for (int h = 0; h < hold; h++) begin
      chk("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
      chk("bp_rsp_rdata", o_rsp_rdata, rdata);
      chk("bp_rsp_err", 32'(o_rsp_err), 32'(err));
      chk("bp_req_ready", 32'(o_req_ready), 32'd0);
      @(negedge clk);
    end
    chk("rsp_req_ready", 32'(o_req_ready), 32'd0);
    chk("rsp_valid_held", 32'(o_rsp_valid), 32'd1);
    tb_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("post_hs_req_ready", 32'(o_req_ready), 32'd1);
  endtask

  // Continuous reads with rsp_ready high; responses must be w+2 cycles apart.
  task automatic stream(input int w);
    int t[8];
    int n;
    n = 0;
    tb_req_valid = 1'b1;
    tb_we        = 1'b0;
    tb_addr      = 32'h0;
    tb_be        = 4'hF;
    tb_rsp_ready = 1'b1;
    for (int c = 0; c < 400 && n < 8; c++) begin
      @(negedge clk);
      if (o_rsp_valid) begin
        t[n] = c;
        n++;
      end
    end
    tb_req_valid = 1'b0;
    if (n < 8) begin
      timeout_fail("stream");
    end else begin
      for (int k = 1; k < 8; k++) chk("stream_period", 32'(t[k] - t[k-1]), 32'(w + 2));
    end
    for (int c = 0; c < 20 && !(o_req_ready && !o_rsp_valid); c++) @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  logic [31:0] rd;
  logic        er;
  logic [31:0] mdl [16];

  initial begin
    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 0, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 0, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h20,   32'h0,        4'hF, 0, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b0, 32'h20,   32'h0,        4'hA, 5, 32'h11BB33DD, 1'b0};
    vecs[6]  = '{1'b1, 32'h0,    32'h12345678, 4'hF, 0, 32'h0,        1'b0};
    vecs[7]  = '{1'b1, 32'h22,   32'hFFFFFFFF, 4'hF, 0, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'h22,   32'h0,        4'hF, 0, 32'h0,        1'b1};
    vecs[9]  = '{1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'h0,    32'h0,        4'hF, 0, 32'h12345678, 1'b0};
    vecs[11] = '{1'b1, 32'h0,    32'h55555555, 4'h0, 0, 32'h0,        1'b0};
    vecs[12] = '{1'b0, 32'h0,    32'h0,        4'hF, 2, 32'h12345678, 1'b0};
    vecs[13] = '{1'b1, 32'hFFC,  32'h0BADC0DE, 4'hF, 0, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 32'hFFC,  32'h0,        4'hF, 0, 32'h0BADC0DE, 1'b0};
    vecs[15] = '{1'b0, 32'h1000, 32'h0,        4'hF, 0, 32'h0,        1'b1};

    rst = 1'b1; sel = 0;
    tb_req_valid = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0; tb_be = '0; tb_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("rst_req_ready", 32'(o_req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      chk("rst_rsp_rdata", o_rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("idle_req_ready", 32'(o_req_ready), 32'd1);
    end
    sel = 0;
    @(negedge clk);

    // Directed vectors on the WAIT_CYCLES=1 instance.
    for (int i = 0; i < NV; i++) begin
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].hold, 2, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Reset arriving in WAIT drops the pending write.
    txn(1'b1, 32'h30, 32'h0, 4'hF, 0, 2, rd, er);
    chk("rstw_init_err", 32'(er), 32'd0);
    tb_req_valid = 1'b1; tb_we = 1'b1; tb_addr = 32'h30; tb_wdata = 32'hCAFEF00D;
    tb_be = 4'hF; tb_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tb_req_valid = 1'b0;
    @(negedge clk);
    chk("rstw_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rstw_req_ready", 32'(o_req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_ready_after", 32'(o_req_ready), 32'd1);
    chk("rstw_valid_after", 32'(o_rsp_valid), 32'd0);
    txn(1'b0, 32'h30, 32'h0, 4'hF, 0, 2, rd, er);
    chk("rstw_read_back", rd, 32'h0);
    chk("rstw_read_err", 32'(er), 32'd0);

    // Randomized traffic against a word-array model.
    for (int k = 0; k < 16; k++) begin
      mdl[k] = $urandom;
      txn(1'b1, 32'h200 + 32'(4 * k), mdl[k], 4'hF, 0, 2, rd, er);
      chk("rnd_init_err", 32'(er), 32'd0);
    end
    for (int it = 0; it < 60; it++) begin
      int          k;
      int          kind;
      logic        we;
      logic [31:0] addr, wdata, exp_rd;
      logic [3:0]  be;
      logic        exp_err;
      k     = $urandom_range(0, 15);
      kind  = $urandom_range(0, 7);
      we    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      be    = 4'($urandom_range(0, 15));
      addr  = 32'h200 + 32'(4 * k);
      if (kind == 0) addr = addr + 32'($urandom_range(1, 3));
      if (kind == 1) addr = 32'h1000 + 32'(4 * $urandom_range(0, 100000));
      exp_err = (addr % 4 != 0) || (addr / 4 >= 1024);
      exp_rd  = 32'h0;
      if (!exp_err) begin
        if (we) begin
          for (int b = 0; b < 4; b++) if (be[b]) mdl[k][8*b +: 8] = wdata[8*b +: 8];
        end else begin
          exp_rd = mdl[k];
        end
      end
      txn(we, addr, wdata, be, $urandom_range(0, 2), 2, rd, er);
      chk($sformatf("rnd%0d_rdata a=%h we=%0d", it, addr, we), rd, exp_rd);
      chk($sformatf("rnd%0d_err a=%h", it, addr), 32'(er), 32'(exp_err));
    end

    // WAIT_CYCLES=0 instance.
    sel = 1;
    @(negedge clk);
    txn(1'b1, 32'h40, 32'h5A5A0F0F, 4'hF, 0, 1, rd, er);
    chk("w0_write_err", 32'(er), 32'd0);
    txn(1'b0, 32'h40, 32'h0, 4'hF, 0, 1, rd, er);
    chk("w0_read_rdata", rd, 32'h5A5A0F0F);
    stream(0);

    // WAIT_CYCLES=3 instance.
    sel = 2;
    @(negedge clk);
    txn(1'b1, 32'h40, 32'h600DCAFE, 4'hF, 0, 4, rd, er);
    chk("w3_write_err", 32'(er), 32'd0);
    txn(1'b0, 32'h40, 32'h0, 4'hF, 3, 4, rd, er);
    chk("w3_read_rdata", rd, 32'h600DCAFE);
    stream(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
